// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher
// Iterative AES inverse cipher (decrypt). One inverse round is applied per
// clock to a single 128-bit state register. The ciphertext enters through a
// valid/ready handshake and the plaintext leaves through another one.
// The key schedule is the forward expanded schedule. Round key i is
// {rkey[4i+3], rkey[4i+2], rkey[4i+1], rkey[4i+0]}. It is read live, so it must
// stay stable while a block is being processed.
//
// Build option: define AES_INV_BACK2BACK_EN to let a new ciphertext be taken on
// the same edge that the finished plaintext is consumed. This removes the
// one-cycle idle bubble between blocks.

module aes_inv_cipher #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  rkey [0:4*(Nr+1)-1],
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt
);

    localparam int CW = $clog2(Nr + 1);

    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FIRST = CW'(Nr - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // ------------------------------------------------------------------
    // GF(2^8) helpers and inverse round functions
    // ------------------------------------------------------------------

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (sh & {8{b[i]}});
            sh  = xtime(sh);
        end
        return acc;
    endfunction

    // b^254 is the multiplicative inverse. It also maps 0 to 0, which the
    // S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] r;
        p = b;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine map first, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = inv_sbox(s[8*k +: 8]);
        end
        return r;
    endfunction

    // Byte k lives at bits [127-8k -: 8]. Column c holds bytes 4c..4c+3, and
    // the row is k mod 4. Row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                r[127-8*(4*c+rr) -: 8] = s[127-8*(4*((c - rr + 4) % 4) + rr) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            r[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            r[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            r[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Storage and combinational nets
    // ------------------------------------------------------------------

    logic [127:0]  state_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]    fsm_r;
    logic          out_valid_r;

    logic [127:0]  state_nx_s;
    logic [CW-1:0] cnt_nx_s;
    logic [1:0]    fsm_nx_s;
    logic          valid_nx_s;

    logic [127:0]  rk_s [0:Nr];
    logic [127:0]  load_s;
    logic [127:0]  sub_s;
    logic [127:0]  round_s;
    logic          ready_s;
    logic          in_ready_s;
    logic          in_fire_s;
    logic          out_fire_s;

    // Regroup the flat word array into whole 128-bit round keys.
    for (genvar g = 0; g <= Nr; g++) begin : g_rk
        assign rk_s[g] = {rkey[4*g+3], rkey[4*g+2], rkey[4*g+1], rkey[4*g]};
    end

    // Initial whitening of a newly accepted block, and one inverse round on
    // the current state. The last round (counter at zero) skips InvMixColumns.
    always_comb begin
        load_s = ct ^ rk_s[Nr];
        sub_s  = inv_sub_bytes(inv_shift_rows(state_r)) ^ rk_s[cnt_r];
        if (cnt_r == CNT_ZERO) begin
            round_s = sub_s;
        end else begin
            round_s = inv_mix_columns(sub_s);
        end
    end

    // Handshake qualifiers. Reset masks in_ready so it wins over an accept.
    always_comb begin
        out_fire_s = out_valid_r & out_ready;
        case (fsm_r)
            IDLE: begin
                ready_s = 1'b1;
            end
            DONE: begin
`ifdef AES_INV_BACK2BACK_EN
                ready_s = out_ready;
`else
                ready_s = 1'b0;
`endif
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
        in_ready_s = ready_s & ~rst;
        in_fire_s  = in_valid & in_ready_s;
    end

    // Next-state logic for the FSM, round counter, state register and out_valid.
    always_comb begin
        fsm_nx_s   = fsm_r;
        cnt_nx_s   = cnt_r;
        state_nx_s = state_r;
        valid_nx_s = out_valid_r;
        case (fsm_r)
            IDLE: begin
                if (in_fire_s) begin
                    state_nx_s = load_s;
                    cnt_nx_s   = CNT_FIRST;
                    fsm_nx_s   = ROUND;
                end else begin
                    fsm_nx_s   = IDLE;
                end
            end
            ROUND: begin
                state_nx_s = round_s;
                if (cnt_r == CNT_ZERO) begin
                    fsm_nx_s   = DONE;
                    valid_nx_s = 1'b1;
                end else begin
                    cnt_nx_s   = cnt_r - CNT_ONE;
                end
            end
            DONE: begin
                // in_fire_s can only be set here when out_fire_s is also set.
                if (in_fire_s) begin
                    state_nx_s = load_s;
                    cnt_nx_s   = CNT_FIRST;
                    fsm_nx_s   = ROUND;
                    valid_nx_s = 1'b0;
                end else if (out_fire_s) begin
                    fsm_nx_s   = IDLE;
                    valid_nx_s = 1'b0;
                end else begin
                    fsm_nx_s   = DONE;
                end
            end
            default: begin
                fsm_nx_s   = IDLE;
                cnt_nx_s   = CNT_ZERO;
                valid_nx_s = 1'b0;
            end
        endcase
    end

    // Register update with a synchronous reset that drops any in-flight block.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r       <= IDLE;
            cnt_r       <= CNT_ZERO;
            state_r     <= 128'h0;
            out_valid_r <= 1'b0;
        end else begin
            fsm_r       <= fsm_nx_s;
            cnt_r       <= cnt_nx_s;
            state_r     <= state_nx_s;
            out_valid_r <= valid_nx_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign pt        = state_r;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Testbench for aes_inv_cipher.
// The reference is a forward AES encryptor built from scratch. Its S-box is
// found by brute-force GF(2^8) inversion. Random plaintexts are encrypted,
// and the DUT must return the original plaintext. A cycle-level timing model
// of the AES-128 instance is compared on every cycle.
`timescale 1ns/1ps

module tb_aes_inv_cipher;

`ifdef AES_INV_BACK2BACK_EN
    localparam bit B2B     = 1'b1;
    localparam int SPACING = 11;
`else
    localparam bit B2B     = 1'b0;
    localparam int SPACING = 12;
`endif

    localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef logic [31:0] ks_t [0:59];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, out_ready;
    logic [127:0] ct, exp_in;
    logic         iv4, iv6, iv8, ir4, ir6, ir8, ov4, ov6, ov8;
    logic [127:0] pt4, pt6, pt8;
    logic [31:0]  rk4 [0:43];
    logic [31:0]  rk6 [0:51];
    logic [31:0]  rk8 [0:59];
    ks_t          ks4, ks6, ks8;
    logic [7:0]   sbox [0:255];
    int           total = 0;
    int           bad = 0;

    aes_inv_cipher #(.Nk(4)) u4 (.clk(clk), .rst(rst), .rkey(rk4), .in_valid(iv4), .in_ready(ir4),
        .ct(ct), .out_valid(ov4), .out_ready(out_ready), .pt(pt4));
    aes_inv_cipher #(.Nk(6)) u6 (.clk(clk), .rst(rst), .rkey(rk6), .in_valid(iv6), .in_ready(ir6),
        .ct(ct), .out_valid(ov6), .out_ready(out_ready), .pt(pt6));
    aes_inv_cipher #(.Nk(8)) u8 (.clk(clk), .rst(rst), .rkey(rk8), .in_valid(iv8), .in_ready(ir8),
        .ct(ct), .out_valid(ov8), .out_ready(out_ready), .pt(pt8));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- reference AES (forward) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, r;
        x = a; y = b; r = 8'h00;
        while (y != 8'h00) begin
            if (y[0]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk, output ks_t w);
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subword(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
    endtask

    function automatic logic [127:0] rkw(input ks_t w, input int i);
        return {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] p, input ks_t w, input int nr);
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [127:0] v;
        v = p ^ rkw(w, 0);
        for (int r = 1; r <= nr; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox[v[127-8*k -: 8]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
            for (int c = 0; c < 4; c++) begin
                if (r != nr) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*c+rr];
                end
            end
            for (int k = 0; k < 16; k++) v[127-8*k -: 8] = s[k];
            v = v ^ rkw(w, r);
        end
        return v;
    endfunction

    // ---------------- cycle model of the AES-128 instance ----------------
    int           cyc = 0;
    bit           m_on = 1'b0;
    bit           m_busy = 1'b0;
    int           m_done_at = 0;
    logic [127:0] m_exp = 128'h0;
    logic [127:0] m_hold = 128'h0;

    // Compare DUT outputs with the model each cycle, then advance the model.
    always @(negedge clk) begin
        bit e_ov, e_ir;
        cyc++;
        e_ov = m_busy && (cyc >= m_done_at);
        e_ir = !rst && (!m_busy || (B2B && e_ov && out_ready));
        if (m_on) begin
            chk("m_out_valid", 128'(ov4), 128'(e_ov));
            chk("m_in_ready", 128'(ir4), 128'(e_ir));
            if (e_ov) chk("m_pt", pt4, m_exp);
            else if (!m_busy) chk("m_pt_idle", pt4, m_hold);
        end
        if (rst) begin
            m_on = 1'b1; m_busy = 1'b0; m_hold = 128'h0;
        end else if (m_on) begin
            if (e_ov && out_ready) begin
                m_busy = 1'b0; m_hold = m_exp;
            end
            if (iv4 && e_ir) begin
                m_busy = 1'b1; m_done_at = cyc + 11; m_exp = exp_in;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_iv(input int w, input logic v);
        case (w)
            4: iv4 = v;
            6: iv6 = v;
            default: iv8 = v;
        endcase
    endtask

    function automatic logic rdy(input int w);
        case (w)
            4: return ir4;
            6: return ir6;
            default: return ir8;
        endcase
    endfunction

    function automatic logic vld(input int w);
        case (w)
            4: return ov4;
            6: return ov6;
            default: return ov8;
        endcase
    endfunction

    function automatic logic [127:0] ptv(input int w);
        case (w)
            4: return pt4;
            6: return pt6;
            default: return pt8;
        endcase
    endfunction

    // Feed one block. Latency is the number of edges after the accept edge
    // until out_valid is seen.
    task automatic run_vec(input int w, input logic [127:0] c, input logic [127:0] p,
                           input int lat, input string nm);
        int k;
        bit got;
        step();
        ct = c; exp_in = p; drive_iv(w, 1'b1);
        k = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk); k++; got = rdy(w);
        end
        step();
        drive_iv(w, 1'b0);
        if (!got) begin
            chk({nm, "_accept"}, 128'(got), 128'(1));
        end else begin
            k = 0; got = 1'b0;
            while (!got && k < 40) begin
                @(posedge clk); k++;
                @(negedge clk); got = vld(w);
            end
            chk({nm, "_latency"}, 128'(k), 128'(lat));
            chk({nm, "_pt"}, ptv(w), p);
        end
    endtask

    task automatic check_released(input int w, input string nm);
        step();
        @(negedge clk);
        chk({nm, "_rel_out_valid"}, 128'(vld(w)), 128'(0));
        chk({nm, "_rel_in_ready"}, 128'(rdy(w)), 128'(1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rp [0:7];
        logic [127:0] rc [0:7];
        int idx, cl, last;
        bit acc;

        rst = 1'b1; out_ready = 1'b0; iv4 = 1'b0; iv6 = 1'b0; iv8 = 1'b0;
        ct = 128'h0; exp_in = 128'h0;

        build_sbox();
        chk("sbox_00", 128'(sbox[0]), 128'h63);
        chk("sbox_53", 128'(sbox[8'h53]), 128'hed);
        expand_key(KEY, 4, ks4);
        expand_key(KEY, 6, ks6);
        expand_key(KEY, 8, ks8);
        chk("ks128_rk10", rkw(ks4, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("model_enc128", encrypt(PT, ks4, 10), CT4);
        chk("model_enc192", encrypt(PT, ks6, 12), CT6);
        chk("model_enc256", encrypt(PT, ks8, 14), CT8);
        // Word 4i+3 carries the first (most significant) word of round key i.
        for (int i = 0; i < 44; i++) rk4[i] = ks4[(i/4)*4 + 3 - i%4];
        for (int i = 0; i < 52; i++) rk6[i] = ks6[(i/4)*4 + 3 - i%4];
        for (int i = 0; i < 60; i++) rk8[i] = ks8[(i/4)*4 + 3 - i%4];

        // Reset behaviour
        @(negedge clk);
        chk("rst_in_ready", 128'(ir4), 128'(0));
        chk("rst_out_valid", 128'(ov4), 128'(0));
        chk("rst_pt", pt4, 128'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 128'(ir4), 128'(1));

        // FIPS-197 AES-128 block
        step();
        out_ready = 1'b1;
        run_vec(4, CT4, PT, 10, "aes128");
        check_released(4, "aes128");

        // Output stall with toggling ct and in_valid held high
        step();
        out_ready = 1'b0;
        run_vec(4, CT4, PT, 10, "stall");
        for (int i = 0; i < 20; i++) begin
            step();
            ct = ~ct; iv4 = 1'b1;
        end
        @(negedge clk);
        chk("stall_pt", pt4, PT);
        chk("stall_in_ready", 128'(ir4), 128'(0));
        chk("stall_out_valid", 128'(ov4), 128'(1));
        step();
        iv4 = 1'b0; out_ready = 1'b1;
        check_released(4, "stall");

        // Reset in the middle of a block
        step();
        ct = CT4; exp_in = PT; iv4 = 1'b1;
        @(negedge clk);
        chk("rstmid_accept_ready", 128'(ir4), 128'(1));
        step();
        iv4 = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_out_valid", 128'(ov4), 128'(0));
        chk("rstmid_pt", pt4, 128'h0);
        chk("rstmid_in_ready", 128'(ir4), 128'(1));
        run_vec(4, CT4, PT, 10, "after_rst");
        check_released(4, "after_rst");

        // Streaming random blocks
        for (int i = 0; i < 8; i++) begin
            rp[i] = {$urandom, $urandom, $urandom, $urandom};
            rc[i] = encrypt(rp[i], ks4, 10);
        end
        step();
        idx = 0; cl = 0; last = -1;
        ct = rc[0]; exp_in = rp[0]; iv4 = 1'b1; out_ready = 1'b1;
        while (idx < 8 && cl < 400) begin
            @(negedge clk);
            cl++;
            acc = ir4;
            step();
            if (acc) begin
                if (last >= 0) chk("rand_spacing", 128'(cl - last), 128'(SPACING));
                last = cl;
                idx++;
                if (idx < 8) begin
                    ct = rc[idx]; exp_in = rp[idx];
                end else begin
                    iv4 = 1'b0;
                end
            end
        end
        chk("rand_accepts", 128'(idx), 128'(8));
        repeat (16) step();

        // AES-192 and AES-256 instances
        run_vec(6, CT6, PT, 12, "aes192");
        check_released(6, "aes192");
        run_vec(8, CT8, PT, 14, "aes256");
        check_released(8, "aes256");

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
